// File: rtl/video_timing_pkg.sv
// Shared types and standard timing sets for the video timing generator.
// The axis helpers are also used by the generator's parameter check.
package video_timing_pkg;

    localparam int CNT_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_STOPPING = 2'd2
    } vtg_state_e;

    typedef struct packed {
        logic [15:0] h_active;
        logic [15:0] h_fp;
        logic [15:0] h_sync;
        logic [15:0] h_bp;
        logic [15:0] v_active;
        logic [15:0] v_fp;
        logic [15:0] v_sync;
        logic [15:0] v_bp;
        logic        hs_pol;
        logic        vs_pol;
    } vtg_timing_t;

    localparam vtg_timing_t VT_720P60 = '{
        h_active: 16'd1280, h_fp: 16'd110, h_sync: 16'd40, h_bp: 16'd220,
        v_active: 16'd720,  v_fp: 16'd5,   v_sync: 16'd5,  v_bp: 16'd20,
        hs_pol: 1'b1, vs_pol: 1'b1};

    localparam vtg_timing_t VT_1080P60 = '{
        h_active: 16'd1920, h_fp: 16'd88, h_sync: 16'd44, h_bp: 16'd148,
        v_active: 16'd1080, v_fp: 16'd4,  v_sync: 16'd5,  v_bp: 16'd36,
        hs_pol: 1'b1, vs_pol: 1'b1};

    localparam vtg_timing_t VT_480P60 = '{
        h_active: 16'd640, h_fp: 16'd16, h_sync: 16'd96, h_bp: 16'd48,
        v_active: 16'd480, v_fp: 16'd10, v_sync: 16'd2,  v_bp: 16'd33,
        hs_pol: 1'b0, vs_pol: 1'b0};

    function automatic int axis_total(input int act, input int fp, input int sync, input int bp);
        return act + fp + sync + bp;
    endfunction

    function automatic bit axis_ok(input int act, input int fp, input int sync, input int bp);
        return (act >= 1) && (fp >= 1) && (sync >= 1) && (bp >= 1) &&
               (axis_total(act, fp, sync, bp) <= 65535);
    endfunction

endpackage

// File: rtl/video_axis_cnt.sv
// One timing axis: wrapping position counter plus active/sync region decode.
// Region order along the axis is active, front porch, sync, back porch.
module video_axis_cnt
    import video_timing_pkg::*;
#(
    parameter int ACTIVE = 1280,
    parameter int FP     = 110,
    parameter int SYNC   = 40,
    parameter int BP     = 220
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             adv,
    output logic [CNT_W-1:0] cnt,
    output logic             last,
    output logic             active,
    output logic             sync
);

    localparam int TOTAL = axis_total(ACTIVE, FP, SYNC, BP);
    localparam logic [CNT_W-1:0] LAST_C  = 16'(TOTAL - 1);
    localparam logic [CNT_W-1:0] ACT_C   = 16'(ACTIVE);
    localparam logic [CNT_W-1:0] SYNC_LO = 16'(ACTIVE + FP);
    localparam logic [CNT_W-1:0] SYNC_HI = 16'(ACTIVE + FP + SYNC);

    // Position counter: cleared while idle, wraps at the end of the axis.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= 16'd0;
        end else if (clr) begin
            cnt <= 16'd0;
        end else if (adv) begin
            cnt <= last ? 16'd0 : (cnt + 16'd1);
        end else begin
            cnt <= cnt;
        end
    end

    assign last   = (cnt == LAST_C);
    assign active = (cnt < ACT_C);
    assign sync   = (cnt >= SYNC_LO) && (cnt < SYNC_HI);

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: IDLE/RUN/STOPPING control over two axis counters,
// all outputs registered one cycle behind the counters.
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int H_ACTIVE = 1280,
    parameter int H_FP     = 110,
    parameter int H_SYNC   = 40,
    parameter int H_BP     = 220,
    parameter int V_ACTIVE = 720,
    parameter int V_FP     = 5,
    parameter int V_SYNC   = 5,
    parameter int V_BP     = 20,
    parameter bit HS_POL   = 1'b1,
    parameter bit VS_POL   = 1'b1
) (
    input  logic        pxl_clk,
    input  logic        rst_n,
    input  logic        en,
    output logic        video_hs,
    output logic        video_vs,
    output logic        video_de,
    output logic [15:0] pos_x,
    output logic [15:0] pos_y,
    output logic        frame_start,
    output logic        line_start,
    output logic        running
);

    if (!axis_ok(H_ACTIVE, H_FP, H_SYNC, H_BP) || !axis_ok(V_ACTIVE, V_FP, V_SYNC, V_BP)) begin : g_bad_params
        $error("video_timing_gen: every region must be >= 1 and each total <= 65535");
    end

    vtg_state_e state, state_next;

    logic [CNT_W-1:0] h_cnt, v_cnt;
    logic h_last, h_active, h_sync;
    logic v_last, v_active, v_sync;
    logic live, frame_last, de_next;

    assign live       = (state != ST_IDLE);
    assign frame_last = h_last && v_last;
    assign de_next    = live && h_active && v_active;

    video_axis_cnt #(.ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP)) u_h_axis (
        .clk(pxl_clk), .rst_n(rst_n), .clr(!live), .adv(live),
        .cnt(h_cnt), .last(h_last), .active(h_active), .sync(h_sync)
    );

    // Vertical axis steps only on horizontal wrap, so its regions change at line boundaries.
    video_axis_cnt #(.ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP)) u_v_axis (
        .clk(pxl_clk), .rst_n(rst_n), .clr(!live), .adv(live && h_last),
        .cnt(v_cnt), .last(v_last), .active(v_active), .sync(v_sync)
    );

    // Control state register.
    always_ff @(posedge pxl_clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: a stop request only takes effect on the last pixel of a frame.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:     state_next = en ? ST_RUN : ST_IDLE;
            ST_RUN:      state_next = en ? ST_RUN : (frame_last ? ST_IDLE : ST_STOPPING);
            ST_STOPPING: state_next = en ? ST_RUN : (frame_last ? ST_IDLE : ST_STOPPING);
            default:     state_next = ST_IDLE;
        endcase
    end

    // Output register; running tracks the state register itself.
    always_ff @(posedge pxl_clk or negedge rst_n) begin
        if (!rst_n) begin
            video_hs    <= ~HS_POL;
            video_vs    <= ~VS_POL;
            video_de    <= 1'b0;
            pos_x       <= 16'd0;
            pos_y       <= 16'd0;
            frame_start <= 1'b0;
            line_start  <= 1'b0;
            running     <= 1'b0;
        end else begin
            video_hs    <= (live && h_sync) ? HS_POL : ~HS_POL;
            video_vs    <= (live && v_sync) ? VS_POL : ~VS_POL;
            video_de    <= de_next;
            pos_x       <= de_next ? h_cnt : 16'd0;
            pos_y       <= de_next ? v_cnt : 16'd0;
            frame_start <= live && (h_cnt == 16'd0) && (v_cnt == 16'd0);
            line_start  <= live && (h_cnt == 16'd0) && v_active;
            running     <= (state_next != ST_IDLE);
        end
    end

endmodule

// File: doc/video_timing_gen.md
VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 1280: active pixels per line.
REQ-002 SHALL have parameter H_FP, default 110: horizontal front porch in pixels.
REQ-003 SHALL have parameter H_SYNC, default 40: hsync width in pixels.
REQ-004 SHALL have parameter H_BP, default 220: horizontal back porch in pixels.
REQ-005 SHALL have parameters V_ACTIVE, V_FP, V_SYNC, V_BP, defaults 720/5/5/20: vertical equivalents, in lines.
REQ-006 SHALL have parameters HS_POL, VS_POL, default 1/1: active level of hsync/vsync.
REQ-007 SHALL have port pxl_clk  in  1  pixel clock; the single clock.
REQ-008 SHALL have port rst_n  in  1  reset, asynchronous and active-low.
REQ-009 SHALL have port en  in  1  run request.
REQ-010 SHALL have port video_hs  out  1  horizontal sync.
REQ-011 SHALL have port video_vs  out  1  vertical sync.
REQ-012 SHALL have port video_de  out  1  data enable.
REQ-013 SHALL have port pos_x  out  16  pixel column; valid while video_de.
REQ-014 SHALL have port pos_y  out  16  line index; valid while video_de.
REQ-015 SHALL have port frame_start  out  1  one-cycle pulse on pixel (0,0).
REQ-016 SHALL have port line_start  out  1  one-cycle pulse on pos_x=0 of each active line.
REQ-017 SHALL have port running  out  1  high while state is RUN or STOPPING.

Function
REQ-018 SHALL hold counters h_cnt (0..H_TOTAL-1) and v_cnt (0..V_TOTAL-1), H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP, V_TOTAL likewise.
REQ-019 SHALL order each line as active (h_cnt 0..H_ACTIVE-1), front porch, sync, back porch; vertical ordering identical, in lines.
REQ-020 SHALL advance h_cnt every cycle in RUN/STOPPING; wrap H_TOTAL-1 -> 0 and increment v_cnt on wrap; v_cnt wraps V_TOTAL-1 -> 0.
REQ-021 SHALL change vertical state only at h_cnt=0, so video_vs edges coincide with line boundaries.
REQ-022 SHALL register all outputs: outputs reflect the counter values of the previous cycle (latency 1).
REQ-023 SHALL assert video_de iff h_cnt<H_ACTIVE and v_cnt<V_ACTIVE; pos_x=h_cnt, pos_y=v_cnt zero-extended; pos_x/pos_y SHALL read 0 when video_de is low.
REQ-024 SHALL drive video_hs=HS_POL during horizontal sync region, ~HS_POL otherwise; video_vs likewise with VS_POL.
REQ-025 SHALL implement states IDLE, RUN, STOPPING.
REQ-026 IDLE -> RUN when en=1; counters start at (0,0) in that cycle's successor; first video_de one cycle later, with frame_start.
REQ-027 RUN -> STOPPING when en=0; STOPPING -> RUN when en=1 again (no frame restart); STOPPING -> IDLE at the last cycle of the frame (h_cnt=H_TOTAL-1, v_cnt=V_TOTAL-1).
REQ-028 In IDLE: counters held at 0, video_de=0, syncs at inactive level, pulses 0, running=0.
REQ-029 frames SHALL never be truncated: deasserting en mid-frame completes that frame's porches and syncs.
REQ-030 counter widths SHALL be 16 bits; parameters SHALL satisfy H_TOTAL, V_TOTAL <= 65535, each region >= 1 (elaboration check).

Reset
REQ-031 SHALL reset asynchronously on rst_n low to state IDLE, counters 0, video_de/frame_start/line_start/running=0, pos_x/pos_y=0, video_hs=~HS_POL, video_vs=~VS_POL.
REQ-032 Reset asserted mid-frame SHALL abort immediately; after release the next frame begins at (0,0) per REQ-026.

Structure
REQ-033 Shared package video_timing_pkg SHALL hold the state enumeration and timing constant sets (720p60, 1080p60, 480p60).
REQ-034 One sub-module video_axis_cnt (counter, wrap, region decode) SHALL be instantiated twice, horizontal and vertical.

Verification (H_ACTIVE=8,H_FP=2,H_SYNC=2,H_BP=2,V_ACTIVE=4,V_FP=1,V_SYNC=1,V_BP=1; H_TOTAL=14, frame=98 cycles)
REQ-035 en rises cycle 0 -> frame_start and video_de at cycle 2, 8 DE cycles per line, 4 lines, frame_start every 98 cycles.
REQ-036 hsync -> high (HS_POL=1) 2 cycles starting 10 cycles after each line_start; vsync high exactly 14 cycles per frame starting on a line boundary.
REQ-037 en dropped at frame cycle 20 -> frame completes, running falls after cycle 98, no further DE.
REQ-038 en dropped then raised within same frame -> uninterrupted 98-cycle cadence, no extra frame_start.
REQ-039 rst_n pulsed mid-line -> outputs at reset values immediately; after release with en=1, frame_start 2 cycles later.
REQ-040 Loopback into the existing timing checker -> H_Active=8, V_Active=4 reported.
